// File: rtl/lsu_riscv.sv
// MA-stage load/store unit: one memory op at a time over a req/gnt/rvalid bus,
// with lane steering, load alignment/extension, misalign detect, timeout and flush.
module lsu_riscv #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst_i,
   input  logic                req_valid_i,
   input  logic                req_we_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_sign_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [XLEN-1:0]     req_wdata_i,
   input  logic                flush_i,
   output logic                stall_o,
   output logic                resp_valid_o,
   output logic [XLEN-1:0]     resp_data_o,
   output logic                misalign_o,
   output logic                bus_err_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [XLEN/8-1:0]   mem_be_o,
   output logic [XLEN-1:0]     mem_wdata_o,
   input  logic                mem_rvalid_i,
   input  logic [XLEN-1:0]     mem_rdata_i,
   input  logic                mem_err_i,
   output logic [1:0]          dbg_state_o
);

   localparam int BE_W  = XLEN / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   // Handshake: mem_req_o is held with stable addr/be/wdata/we until the cycle mem_gnt_i is
   // high; mem_rvalid_i (with mem_err_i) may arrive in that same cycle or any later cycle.
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_flag;
   logic                r_we, r_sign;
   logic [1:0]          r_size;
   logic [OFF_W-1:0]    r_off;
   logic                r_mem_req, r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [BE_W-1:0]     r_mem_be;
   logic [XLEN-1:0]     r_mem_wdata;
   logic                r_resp_valid, r_misalign, r_bus_err;
   logic [XLEN-1:0]     r_resp_data;

   logic                w_accept, w_complete, w_to, w_misalign, w_timeout, w_busy;
   logic [OFF_W-1:0]    w_off;
   logic [2:0]          w_off3;
   logic [7:0]          w_be_base;
   logic [BE_W-1:0]     w_be;
   logic [XLEN-1:0]     w_wdata, w_shift, w_mask, w_ld;
   logic                w_sbit;

   assign w_off     = req_addr_i[OFF_W-1:0];
   assign w_off3    = 3'(w_off);
   assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
   assign w_timeout = (TIMEOUT_CYC != 0) && w_busy && (r_cnt >= TO_LAST);

   always_comb begin
      w_misalign = 1'b0;
      w_be_base  = 8'h01;
      case (req_size_i)
         2'b00: begin w_misalign = 1'b0;                       w_be_base = 8'h01; end
         2'b01: begin w_misalign = w_off3[0];                  w_be_base = 8'h03; end
         2'b10: begin w_misalign = |w_off3[1:0];               w_be_base = 8'h0F; end
         default: begin w_misalign = (XLEN < 64) || (|w_off3); w_be_base = 8'hFF; end
      endcase
   end

   assign w_be = BE_W'(w_be_base) << w_off;

   // Each byte lane takes the store byte that lands on it for the given access size.
   always_comb begin
      w_wdata = '0;
      for (int i = 0; i < BE_W; i++) begin
         case (req_size_i)
            2'b00:   w_wdata[i*8 +: 8] = req_wdata_i[7:0];
            2'b01:   w_wdata[i*8 +: 8] = req_wdata_i[(i % 2)*8 +: 8];
            2'b10:   w_wdata[i*8 +: 8] = req_wdata_i[(i % 4)*8 +: 8];
            default: w_wdata[i*8 +: 8] = req_wdata_i[i*8 +: 8];
         endcase
      end
   end

   // Load formatting: the mask's top bit selects the sign bit of the access.
   assign w_shift = mem_rdata_i >> {r_off, 3'b000};
   assign w_mask  = (XLEN'(1) << (7'd8 << r_size)) - XLEN'(1);
   assign w_sbit  = |(w_shift & (w_mask & ~(w_mask >> 1)));
   assign w_ld    = (w_shift & w_mask) | ((r_sign && w_sbit) ? ~w_mask : '0);

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_complete  = 1'b0;
      w_to        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid_i && !flush_i) begin
               w_accept    = 1'b1;
               w_state_nxt = w_misalign ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (flush_i && !mem_gnt_i) begin
               w_state_nxt = S_IDLE;
            end else if (mem_gnt_i && mem_rvalid_i) begin
               w_complete  = 1'b1;
               w_state_nxt = flush_i ? S_IDLE : S_RESP;
            end else if (mem_gnt_i) begin
               w_state_nxt = S_WAIT;
            end else if (w_timeout) begin
               w_to        = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               w_complete  = 1'b1;
               w_state_nxt = (r_flag || flush_i) ? S_IDLE : S_RESP;
            end else if (w_timeout) begin
               w_to        = 1'b1;
               w_state_nxt = (r_flag || flush_i) ? S_IDLE : S_RESP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_flag       <= 1'b0;
         r_we         <= 1'b0;
         r_sign       <= 1'b0;
         r_size       <= 2'b00;
         r_off        <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_be     <= '0;
         r_mem_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_misalign   <= 1'b0;
         r_bus_err    <= 1'b0;
         r_resp_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_busy && (w_state_nxt == S_REQ || w_state_nxt == S_WAIT)) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         // A squashed op that already owns the bus drains silently through WAIT.
         r_flag <= (w_state_nxt == S_WAIT) && (r_flag || flush_i);
         if (w_accept) begin
            r_we        <= req_we_i;
            r_sign      <= req_sign_i;
            r_size      <= req_size_i;
            r_off       <= w_off;
            r_mem_we    <= req_we_i;
            r_mem_addr  <= {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
         end
         r_mem_req    <= (w_state_nxt == S_REQ);
         r_resp_valid <= (w_state_nxt == S_RESP);
         r_misalign   <= w_accept && w_misalign;
         r_bus_err    <= (w_state_nxt == S_RESP) && ((w_complete && mem_err_i) || w_to);
         r_resp_data  <= ((w_state_nxt == S_RESP) && w_complete && !mem_err_i && !r_we) ? w_ld : '0;
      end
   end

   assign stall_o      = w_busy || ((r_state == S_IDLE) && req_valid_i && !flush_i);
   assign resp_valid_o = r_resp_valid && !flush_i;
   assign misalign_o   = r_misalign && !flush_i;
   assign bus_err_o    = r_bus_err && !flush_i;
   assign resp_data_o  = r_resp_data;
   assign mem_req_o    = r_mem_req;
   assign mem_we_o     = r_mem_we;
   assign mem_addr_o   = r_mem_addr;
   assign mem_be_o     = r_mem_be;
   assign mem_wdata_o  = r_mem_wdata;
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv: drivers push expected responses, a negedge monitor pops and compares.
module tb_lsu_riscv;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_sign_i = 1'b0, flush_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic [31:0] req_addr_i = '0, req_wdata_i = '0;
   logic        stall_o, resp_valid_o, misalign_o, bus_err_o;
   logic [31:0] resp_data_o;
   logic        mem_req_o, mem_we_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
   logic [3:0]  mem_be_o;
   logic [1:0]  dbg_state_o;

   logic [33:0] exp_q[$];   // {misalign, bus_err, data}
   int          n_vec = 0;
   int          n_err = 0;

   lsu_riscv #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_sign_i(req_sign_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .flush_i(flush_i), .stall_o(stall_o),
      .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .misalign_o(misalign_o),
      .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .mem_err_i(mem_err_i), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_i && resp_valid_o) begin
         if (exp_q.size() == 0) begin
            chk("spurious_resp", 64'd1, 64'd0);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            chk("resp_data", resp_data_o, e[31:0]);
            chk("resp_bus_err", bus_err_o, e[32]);
            chk("resp_misalign", misalign_o, e[33]);
         end
      end
   end

   task automatic present(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata);
      req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_sign_i = sign;
      req_addr_i = addr; req_wdata_i = wdata;
   endtask

   // Aligned op: gnt after gnt_wait cycles; fast = rvalid in the grant cycle.
   task automatic do_op(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_wait, input logic fast,
                        input logic [31:0] rdata, input logic err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_data);
      exp_q.push_back({1'b0, err, exp_data});
      present(we, size, sign, addr, wdata);
      @(negedge clk); chk("stall_accept", stall_o, 1);
      @(posedge clk); #1; req_valid_i = 1'b0;
      repeat (gnt_wait) begin
         @(negedge clk); chk("req_hold", mem_req_o, 1);
         @(posedge clk); #1;
      end
      mem_gnt_i = 1'b1;
      if (fast) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err; end
      @(negedge clk);
      chk("mem_req", mem_req_o, 1);
      chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
      chk("mem_be", mem_be_o, exp_be);
      chk("mem_wdata", mem_wdata_o, exp_wd);
      chk("mem_we", mem_we_o, we);
      chk("stall_req", stall_o, 1);
      @(posedge clk); #1; mem_gnt_i = 1'b0;
      if (!fast) begin
         mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
         @(negedge clk); chk("req_dropped", mem_req_o, 0); chk("stall_wait", stall_o, 1);
         @(posedge clk); #1;
      end
      mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
      @(negedge clk); chk("resp_timing", resp_valid_o, 1); chk("stall_resp", stall_o, 0);
      @(posedge clk); #1;
   endtask

   task automatic do_mis(input logic [1:0] size, input logic [31:0] addr);
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      present(1'b0, size, 1'b0, addr, 32'h0);
      @(negedge clk); chk("mis_stall", stall_o, 1);
      @(posedge clk); #1; req_valid_i = 1'b0;
      @(negedge clk); chk("mis_timing", resp_valid_o, 1); chk("mis_no_req", mem_req_o, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1; rst_i = 1'b0;
      @(negedge clk);
      chk("rst_ctrl", {resp_valid_o, misalign_o, bus_err_o, mem_req_o, mem_we_o, stall_o}, 0);
      chk("rst_data", {mem_addr_o, mem_wdata_o}, 0);
      chk("rst_be_resp", {mem_be_o, resp_data_o}, 0);
      @(posedge clk); #1;

      //     we    sz     sg    addr      wdata         gw fast rdata         err  be     wd            data
      do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF);
      do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        0, 1'b0, 32'h80FFFFFF, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80);
      do_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        1, 1'b0, 32'h80FFFFFF, 1'b0, 4'h8, 32'h0,        32'h00000080);
      do_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 0, 1'b0, 32'h5555AAAA, 1'b0, 4'hC, 32'hABCDABCD, 32'h0);
      do_op(1'b0, 2'b01, 1'b1, 32'h106, 32'h0,        0, 1'b1, 32'h80011234, 1'b0, 4'hC, 32'h0,        32'hFFFF8001);
      do_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 2, 1'b0, 32'h0,        1'b0, 4'h2, 32'hA5A5A5A5, 32'h0);
      do_op(1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        2, 1'b0, 32'h12345678, 1'b1, 4'hF, 32'h0,        32'h0);

      do_mis(2'b10, 32'h101);
      do_mis(2'b01, 32'h103);
      do_mis(2'b11, 32'h100);

      // Grant withheld: request held 8 cycles, then a bus-error response.
      exp_q.push_back({1'b0, 1'b1, 32'h0});
      present(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
      @(posedge clk); #1; req_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); chk("to_req_hold", mem_req_o, 1);
         @(posedge clk); #1;
      end
      @(negedge clk); chk("to_resp_timing", resp_valid_o, 1); chk("to_req_dropped", mem_req_o, 0);
      @(posedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
      @(negedge clk); chk("late_rvalid_idle", {dbg_state_o, stall_o}, 0);
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      @(negedge clk); chk("late_rvalid_no_resp", resp_valid_o, 0);
      @(posedge clk); #1;

      // Flush in WAIT, then rvalid: bus handshake drains with no response.
      present(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
      @(posedge clk); #1; req_valid_i = 1'b0; mem_gnt_i = 1'b1;
      @(posedge clk); #1; mem_gnt_i = 1'b0; flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11111111;
      @(negedge clk); chk("flush_drain_stall", stall_o, 1);
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      @(negedge clk); chk("flush_wait_idle", {dbg_state_o, resp_valid_o}, 0);
      @(posedge clk); #1;

      // Flush in REQ without grant: request dropped at once.
      present(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
      @(posedge clk); #1; req_valid_i = 1'b0; flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0;
      @(negedge clk); chk("flush_req_idle", {dbg_state_o, mem_req_o, resp_valid_o}, 0);
      @(posedge clk); #1;

      // Reset in REQ of a store, then a stale rvalid.
      present(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D);
      @(posedge clk); #1; req_valid_i = 1'b0;
      @(negedge clk); chk("pre_rst_req", mem_req_o, 1);
      @(posedge clk); #1; rst_i = 1'b1;
      @(posedge clk); #1; rst_i = 1'b0;
      @(negedge clk);
      chk("midrst_ctrl", {resp_valid_o, misalign_o, bus_err_o, mem_req_o, mem_we_o, stall_o}, 0);
      chk("midrst_data", {mem_addr_o, mem_wdata_o}, 0);
      chk("midrst_be_resp", {mem_be_o, resp_data_o}, 0);
      @(posedge clk); #1; mem_rvalid_i = 1'b1;
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      @(negedge clk); chk("stale_rvalid_no_resp", resp_valid_o, 0);

      repeat (3) @(posedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
